// File: rtl/config_access_sync.sv
// Synchronises quasi-static configuration bits into the UserCLK domain and
// commits them to fabric only after they have stayed stable for HOLD_CYCLES.
module config_access_sync #(
  parameter int unsigned NoConfigBits = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned HOLD_CYCLES  = 4
) (
  input  logic                    UserCLK,
  input  logic                    resetn,
  input  logic [NoConfigBits-1:0] ConfigBits,
  input  logic                    freeze,
  output logic [NoConfigBits-1:0] C_bit,
  output logic                    C_valid,
  output logic                    C_update
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntMax = CntW'(HOLD_CYCLES);

  typedef enum logic [0:0] {StIdle, StSettle} state_e;

  state_e                  state_q;
  logic [NoConfigBits-1:0] sync_q [SYNC_STAGES];
  logic [NoConfigBits-1:0] cand_q;
  logic [CntW-1:0]         cnt_q;
  logic [NoConfigBits-1:0] s;

  // Only the first stage ever samples the asynchronous ConfigBits.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ConfigBits;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cand_q   <= '0;
      cnt_q    <= '0;
      C_bit    <= '0;
      C_valid  <= 1'b0;
      C_update <= 1'b0;
    end else begin
      C_update <= 1'b0;
      case (state_q)
        StIdle: begin
          if ((s != C_bit) || !C_valid) begin
            cand_q  <= s;
            cnt_q   <= CntOne;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          if ((s != cand_q) && C_valid && (s == C_bit)) begin
            // Input reverted to the committed value: drop the candidate silently.
            state_q <= StIdle;
          end else if (s != cand_q) begin
            cand_q <= s;
            cnt_q  <= CntOne;
          end else if (cnt_q < CntMax) begin
            cnt_q <= cnt_q + CntOne;
          end else if (!freeze) begin
            C_bit    <= cand_q;
            C_valid  <= 1'b1;
            C_update <= 1'b1;
            state_q  <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_access_sync.sv
// Directed bench for config_access_sync at default parameters (8 bits, 2 stages, hold 4).
module tb_config_access_sync;

  logic       UserCLK;
  logic       resetn;
  logic [7:0] ConfigBits;
  logic       freeze;
  logic [7:0] C_bit;
  logic       C_valid;
  logic       C_update;

  int vectors;
  int miscompares;
  int pulses;

  config_access_sync #(
    .NoConfigBits(8),
    .SYNC_STAGES (2),
    .HOLD_CYCLES (4)
  ) dut (
    .UserCLK   (UserCLK),
    .resetn    (resetn),
    .ConfigBits(ConfigBits),
    .freeze    (freeze),
    .C_bit     (C_bit),
    .C_valid   (C_valid),
    .C_update  (C_update)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  // Advance n edges, counting C_update pulses seen after each edge.
  task automatic tick_count(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (C_update === 1'b1) pulses++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pulses      = 0;
    resetn      = 1'b0;
    ConfigBits  = 8'hA5;
    freeze      = 1'b0;

    // Power-up
    tick();
    tick();
    tick();
    check("rst_cbit", 32'(C_bit), 32'h00);
    check("rst_valid", 32'(C_valid), 32'h0);
    check("rst_update", 32'(C_update), 32'h0);
    resetn = 1'b1;
    tick_count(6);
    check("pwr_e6_cbit", 32'(C_bit), 32'h00);
    check("pwr_e6_valid", 32'(C_valid), 32'h0);
    check("pwr_e6_pulses", 32'(pulses), 32'd0);
    tick();
    check("pwr_e7_cbit", 32'(C_bit), 32'hA5);
    check("pwr_e7_valid", 32'(C_valid), 32'h1);
    check("pwr_e7_update", 32'(C_update), 32'h1);
    tick();
    check("pwr_e8_update", 32'(C_update), 32'h0);
    pulses = 0;
    tick_count(8);
    check("pwr_idle_pulses", 32'(pulses), 32'd0);
    check("pwr_idle_cbit", 32'(C_bit), 32'hA5);

    // Clean change: edges e..e+5 keep old value, e+6 commits
    ConfigBits = 8'h3C;
    pulses = 0;
    tick_count(6);
    check("clean_e5_cbit", 32'(C_bit), 32'hA5);
    check("clean_e5_pulses", 32'(pulses), 32'd0);
    tick();
    check("clean_e6_cbit", 32'(C_bit), 32'h3C);
    check("clean_e6_update", 32'(C_update), 32'h1);
    tick();
    check("clean_e7_update", 32'(C_update), 32'h0);
    tick_count(4);

    // Unstable input, final change before edge ef
    pulses = 0;
    ConfigBits = 8'h3D;
    tick_count(2);
    ConfigBits = 8'h3C;
    tick_count(2);
    ConfigBits = 8'h3D;
    tick_count(6);
    check("unstab_ef5_cbit", 32'(C_bit), 32'h3C);
    check("unstab_ef5_pulses", 32'(pulses), 32'd0);
    tick();
    check("unstab_ef6_cbit", 32'(C_bit), 32'h3D);
    check("unstab_ef6_update", 32'(C_update), 32'h1);
    pulses = 0;
    tick_count(6);
    check("unstab_after_pulses", 32'(pulses), 32'd0);

    // Reverted glitch
    ConfigBits = 8'h00;
    tick_count(2);
    ConfigBits = 8'h3D;
    pulses = 0;
    tick_count(12);
    check("glitch_cbit", 32'(C_bit), 32'h3D);
    check("glitch_pulses", 32'(pulses), 32'd0);
    check("glitch_valid", 32'(C_valid), 32'h1);

    // Freeze holds the committed value until released
    freeze = 1'b1;
    ConfigBits = 8'hFF;
    pulses = 0;
    tick_count(20);
    check("frz_cbit", 32'(C_bit), 32'h3D);
    check("frz_pulses", 32'(pulses), 32'd0);
    freeze = 1'b0;
    tick();
    check("frz_rel_cbit", 32'(C_bit), 32'hFF);
    check("frz_rel_update", 32'(C_update), 32'h1);
    tick();
    check("frz_rel_next_update", 32'(C_update), 32'h0);
    tick_count(4);

    // Reset mid-settle: after edge h+3 the counter is at 2
    ConfigBits = 8'h5A;
    tick_count(4);
    check("mid_cbit_pre", 32'(C_bit), 32'hFF);
    resetn = 1'b0;
    #1;
    check("mid_rst_cbit", 32'(C_bit), 32'h00);
    check("mid_rst_valid", 32'(C_valid), 32'h0);
    check("mid_rst_update", 32'(C_update), 32'h0);
    tick();
    tick();
    resetn = 1'b1;
    pulses = 0;
    tick_count(6);
    check("mid_e6_valid", 32'(C_valid), 32'h0);
    check("mid_e6_pulses", 32'(pulses), 32'd0);
    tick();
    check("mid_e7_cbit", 32'(C_bit), 32'h5A);
    check("mid_e7_valid", 32'(C_valid), 32'h1);
    check("mid_e7_update", 32'(C_update), 32'h1);
    tick();
    check("mid_e8_update", 32'(C_update), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/config_access_sync.md
Name: config_access_sync

Overview:
- Parametrised successor to the plain config-bit breakout BEL.
- Takes NoConfigBits configuration bits, which are quasi-static and asynchronous to the user clock. Synchronises them into the UserCLK domain and publishes them to fabric top only after they have been stable for a programmable hold time.
- Gives user logic glitch-free config values during partial reconfiguration, plus an update strobe, a valid flag and a freeze control.

Parameters:
- NoConfigBits, 8, number of config bits passed through (1..32).
- SYNC_STAGES, 2, synchroniser depth (>=2).
- HOLD_CYCLES, 4, consecutive stable cycles required before commit (>=1).

Ports:
- UserCLK  input  1  user clock.
- resetn  input  1  asynchronous active-low reset.
- ConfigBits  input  NoConfigBits  config-bit input (GLOBAL), asynchronous to UserCLK.
- freeze  input  1  EXTERNAL; while high, C_bit must not change.
- C_bit  output  NoConfigBits  EXTERNAL; committed config value, registered.
- C_valid  output  1  EXTERNAL; high once the first value has been committed.
- C_update  output  1  EXTERNAL; one-cycle pulse in the cycle after each commit.

Behaviour:
- Reset:
  - Asynchronous assert, release on next UserCLK edge.
  - Sync chain, cand, cnt, C_bit and C_update clear to 0.
  - C_valid clears to 0. State goes to IDLE.
- Synchroniser: SYNC_STAGES flops per bit. S denotes the last stage. No other logic samples ConfigBits directly.
- cand: NoConfigBits-wide candidate register.
- cnt: counter, width clog2(HOLD_CYCLES+1). Saturates at HOLD_CYCLES and never wraps.
- IDLE:
  - If S != C_bit or C_valid==0: cand<=S, cnt<=1, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE, evaluated in priority order:
  1. If S != cand and C_valid==1 and S == C_bit: go to IDLE. This is a reverted glitch, so no commit and no pulse.
  2. Else if S != cand: cand<=S, cnt<=1 (restart).
  3. Else if cnt < HOLD_CYCLES: cnt<=cnt+1.
  4. Else if freeze==0: C_bit<=cand, C_valid<=1, C_update<=1, go to IDLE (commit).
  5. Else (freeze==1): hold cand and cnt, stay in SETTLE. Commit occurs on the first edge with freeze==0 and S==cand. A change of S while frozen restarts via rule 2.
- Latency:
  - ConfigBits change settled before edge e is sampled by FSM at edge e+SYNC_STAGES.
  - Commit at edge e+SYNC_STAGES+HOLD_CYCLES; the new C_bit is visible after that edge.
  - Defaults: 6 edges.
- C_update:
  - High for exactly one cycle per commit; deasserts on the following edge.
  - Never asserts without a commit. A re-commit of an identical value only happens as the first (C_valid-setting) commit.
- Width rules: all compares are full-width, NoConfigBits bits; no partial-bit commits. C_bit is updated atomically.
- freeze has no effect in IDLE.
- Reset mid-SETTLE: all state clears. C_valid drops to 0 immediately (asynchronous) and the FSM restarts from IDLE.

Test Plan:
- Power-up: hold resetn=0, ConfigBits=8'hA5 -> C_bit=0, C_valid=0, C_update=0. Release resetn -> C_bit=8'hA5 and C_valid=1 after edge 7 (SYNC_STAGES+HOLD_CYCLES+1). One C_update pulse only.
- Clean change: idle at 8'hA5, set ConfigBits=8'h3C before edge e -> C_bit=8'h3C after edge e+6. C_update high for the cycle after e+6 only.
- Unstable input: toggle ConfigBits 8'h3C->8'h3D->8'h3C->8'h3D every 2 cycles, then hold 8'h3D -> no C_bit change until 6 edges after the final change. Then C_bit=8'h3D with a single pulse.
- Reverted glitch: C_bit=8'h3D, ConfigBits=8'h00 for 2 cycles then back to 8'h3D -> C_bit stays 8'h3D, no C_update.
- Freeze: freeze=1 before changing ConfigBits to 8'hFF, hold freeze for 20 cycles -> C_bit unchanged. Drop freeze -> C_bit=8'hFF on the next edge, one C_update pulse.
- Reset mid-settle: resetn=0 at cnt=2 -> C_bit=0 and C_valid=0 immediately. After release, power-up timing applies.
